// File: rtl/exe_mem_pkg.sv
// Shared types for the Execute->Memory pipeline boundary: payload record
// carried by each buffer entry and the skid-buffer occupancy states.
package exe_mem_pkg;

  localparam int DEF_WIDTH    = 48;
  localparam int DEF_REG_BITS = 5;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]    alu_out;
    logic [DEF_WIDTH-1:0]    store_data;
    logic [DEF_REG_BITS-1:0] rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic [3:0]              nzvc;
    logic                    set_flags;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ex_mem_pipe_flag_reg.sv
// Architectural NZVC status register: 4-bit, write-enabled, cleared by a
// synchronous active-low reset.
module flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 4'b0000;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Execute->Memory boundary: 2-entry skid buffer with a registered ex_ready,
// plus the NZVC status register committed as each instruction drains.
module ex_mem_pipe
  import exe_mem_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [WIDTH-1:0]    ex_alu_out,
  input  logic [3:0]          ex_nzvc,
  input  logic                ex_set_flags,
  input  logic [WIDTH-1:0]    ex_store_data,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                flush,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [WIDTH-1:0]    mem_alu_out,
  output logic [WIDTH-1:0]    mem_store_data,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic [3:0]          flags_nzvc
);

  skid_state_t     state, state_nxt;
  ex_mem_payload_t in_p0;
  ex_mem_payload_t main_p1, skid_p1;
  logic            ex_ready_q;
  logic            accept, drain;
  logic            ld_main_ex, ld_main_skid, ld_skid;
  logic            flag_we;

  always_comb begin
    in_p0            = '0;
    in_p0.alu_out    = ex_alu_out;
    in_p0.store_data = ex_store_data;
    in_p0.rd         = ex_rd;
    in_p0.reg_write  = ex_reg_write;
    in_p0.mem_read   = ex_mem_read;
    in_p0.mem_write  = ex_mem_write;
    in_p0.nzvc       = ex_nzvc;
    in_p0.set_flags  = ex_set_flags;
  end

  assign ex_ready  = ex_ready_q;
  assign mem_valid = (state != EMPTY);
  assign accept    = ex_valid && ex_ready_q;
  assign drain     = mem_valid && mem_ready;

  // The flag commit ignores flush: a draining instruction has already left.
  assign flag_we   = drain && main_p1.set_flags;

  always_comb begin
    state_nxt    = state;
    ld_main_ex   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          ld_main_ex = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          ld_main_ex = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt    = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_ex   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ex_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      ex_ready_q <= (state_nxt != FULL);
    end
  end

  // Stage p1: buffer entries, written only when an instruction lands in them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (ld_main_ex) begin
        main_p1 <= in_p0;
      end else if (ld_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (ld_skid) begin
        skid_p1 <= in_p0;
      end
    end
  end

  assign mem_alu_out    = main_p1.alu_out;
  assign mem_store_data = main_p1.store_data;
  assign mem_rd         = main_p1.rd;
  assign mem_reg_write  = mem_valid && main_p1.reg_write;
  assign mem_mem_read   = mem_valid && main_p1.mem_read;
  assign mem_mem_write  = mem_valid && main_p1.mem_write;

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (flag_we),
    .d     (main_p1.nzvc),
    .q     (flags_nzvc)
  );

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Pipeline boundary between the Execute stage (ALU, 48-bit datapath) and the Memory stage.
- Registers the ALU result, store data and control fields, and decouples the two stages with a valid/ready handshake through a 2-entry skid buffer.
- Holds the architectural NZVC status register, committed as each instruction leaves toward Memory, so a flush never corrupts flags.

Parameters:
- WIDTH, 48, datapath width; matches the ALU result width.
- REG_BITS, 5, destination register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ex_valid  in  1  Execute presents an instruction.
- ex_ready  out  1  block can accept this cycle; registered, equals "skid entry empty".
- ex_alu_out  in  WIDTH  ALU result.
- ex_nzvc  in  4  ALU flags {N,Z,V,C}.
- ex_set_flags  in  1  instruction updates the status register.
- ex_store_data  in  WIDTH  data for stores.
- ex_rd  in  REG_BITS  destination register.
- ex_reg_write  in  1  writes the register file.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- flush  in  1  kill all buffered instructions and any incoming one this cycle.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  Memory consumes the head this cycle.
- mem_alu_out  out  WIDTH  head fields (same order as ex_* fields).
- mem_store_data  out  WIDTH
- mem_rd  out  REG_BITS
- mem_reg_write  out  1
- mem_mem_read  out  1
- mem_mem_write  out  1
- flags_nzvc  out  4  committed status register.

Behaviour:
- Transfers:
  - Accept = ex_valid && ex_ready.
  - Drain = mem_valid && mem_ready.
- Storage: main entry drives the mem_* outputs directly from registers; skid entry holds overflow.
- States:
  - EMPTY: no entry valid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions (flush = 0):
  - EMPTY: accept -> ONE; the incoming instruction goes to main.
  - ONE:
    - accept & drain -> ONE; main is replaced.
    - accept & !drain -> FULL; the incoming instruction goes to skid.
    - drain only -> EMPTY.
    - neither -> ONE, held.
  - FULL: ex_ready = 0, so no accept.
    - drain -> ONE; skid moves to main.
    - no drain -> FULL, held.
- Latency: one cycle from accept to mem_valid when EMPTY. Full throughput of one instruction per cycle while mem_ready = 1.
- ex_ready = (state != FULL). It is registered, so it has no combinational path from mem_ready.
- Status register:
  - On drain, if the head's set_flags = 1, flags_nzvc <= head nzvc.
  - Otherwise flags_nzvc holds.
  - Each entry stores its own nzvc and set_flags.
- Flush:
  - Next state is EMPTY; both valids clear; the incoming instruction is dropped.
  - A drain in the same cycle still commits flags, because that instruction has left.
  - Payload registers may keep stale values, but mem_valid = 0.
- Payload: entries capture fields only on write. Outputs are stable while mem_valid && !mem_ready; a bench must check this.
- Reset (rst_n = 0 at a clock edge), including mid-operation:
  - State becomes EMPTY.
  - mem_valid = 0, ex_ready = 1, flags_nzvc = 4'b0000.
  - All mem_* payload outputs = 0.
  - Reset takes priority over flush and over transfers.
- Control is gated by valid: mem_reg_write, mem_mem_read and mem_mem_write are meaningful only when mem_valid = 1. When invalid they are forced to 0 at the outputs.

Decomposition:
- Shared package exe_mem_pkg:
  - WIDTH and REG_BITS defaults.
  - Typedef ex_mem_payload_t: a struct of alu_out, store_data, rd, reg_write, mem_read, mem_write, nzvc, set_flags.
  - Typedef skid_state_t enum {EMPTY, ONE, FULL}.
- One natural sub-module, flag_reg: a 4-bit synchronous active-low-reset register with write enable. It keeps the architectural flags separate from the buffer.

Test Plan:
- Reset then single instruction: ex_alu_out = 48'h0000_0000_002A, rd = 3, reg_write = 1, set_flags = 1, nzvc = 4'b0000, mem_ready = 1 -> mem_valid the next cycle with the same fields; flags_nzvc = 0000 after the drain.
- Backpressure: mem_ready = 0, send A = 48'h1 then B = 48'h2 -> ex_ready goes 0 after B. C is held at ex. mem_alu_out is stable at 1 for 5 cycles. Raising mem_ready yields 1, 2, then C in order with no loss or duplication.
- Flags on commit: instruction with nzvc = 4'b0100, set_flags = 1, held at head with mem_ready = 0 -> flags_nzvc stays at its old value 0000 until the drain cycle, then becomes 0100. A following instruction with set_flags = 0 leaves it at 0100.
- Flush in FULL state while ex_valid = 1 -> next cycle mem_valid = 0, ex_ready = 1. Flags are unchanged and no flushed instruction ever appears at mem.
- Flush coincident with a drain of a set_flags instruction carrying nzvc = 4'b1001 -> flags_nzvc = 1001; buffer EMPTY.
- Reset asserted mid-stream in FULL state -> next edge: mem_valid = 0, ex_ready = 1, flags_nzvc = 0000, all mem_* = 0.
